// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: RAW hazard stalls, branch flushes, data-memory freeze.
// Define FORWARDING_EN to restrict hazard stalls to load-use only.
module pipe_hazard_ctrl #(
   parameter int MEM_WAIT_CYCLES = 4,
   parameter int CNT_W           = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       id_src1,
   input  logic [3:0]       id_src2,
   input  logic             id_two_src,
   input  logic             id_valid,
   input  logic [3:0]       exe_dest,
   input  logic             exe_wb_en,
   input  logic             exe_mem_r_en,
   input  logic [3:0]       mem_dest,
   input  logic             mem_wb_en,
   input  logic             mem_req,
   input  logic             branch_taken,
   output logic             pc_freeze,
   output logic             ifid_freeze,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             global_freeze,
   output logic             mem_ready,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam int WCW = (MEM_WAIT_CYCLES > 1) ? $clog2(MEM_WAIT_CYCLES) : 1;
   localparam logic [WCW-1:0] LOAD = WCW'(MEM_WAIT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WCW-1:0]   cnt_q, cnt_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   logic exe_hit;
   logic mem_hit;
   logic load_use;
   logic hazard;
   logic haz_stall;

   always_comb begin
      exe_hit  = exe_wb_en && ((exe_dest == id_src1) ||
                 (id_two_src && (exe_dest == id_src2)));
      mem_hit  = mem_wb_en && ((mem_dest == id_src1) ||
                 (id_two_src && (mem_dest == id_src2)));
      load_use = exe_mem_r_en && exe_hit;
`ifdef FORWARDING_EN
      hazard   = id_valid && load_use;
`else
      hazard   = id_valid && (exe_hit || mem_hit || load_use);
`endif
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (mem_req) begin
               if (MEM_WAIT_CYCLES == 1) begin
                  state_d = S_DONE;
               end else begin
                  cnt_d   = LOAD;
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == WCW'(1)) state_d = S_DONE;
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Freeze dominates; a branch squashes ID so its hazard is moot.
   always_comb begin
      global_freeze = (state_q == S_WAIT) || ((state_q == S_IDLE) && mem_req);
      mem_ready     = (state_q == S_DONE);
      pc_freeze     = 1'b0;
      ifid_freeze   = 1'b0;
      ifid_flush    = 1'b0;
      idex_flush    = 1'b0;
      haz_stall     = 1'b0;
      if (!global_freeze) begin
         if (branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
         end else if (hazard) begin
            pc_freeze   = 1'b1;
            ifid_freeze = 1'b1;
            idex_flush  = 1'b1;
            haz_stall   = 1'b1;
         end
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if ((global_freeze || haz_stall) && (stall_cnt_q != '1))
         stall_cnt_d = stall_cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl.
module tb_pipe_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  id_src1, id_src2, exe_dest, mem_dest;
   logic        id_two_src, id_valid, exe_wb_en, exe_mem_r_en;
   logic        mem_wb_en, mem_req, branch_taken;
   logic        pc_freeze, ifid_freeze, ifid_flush, idex_flush;
   logic        global_freeze, mem_ready;
   logic [15:0] stall_cnt;

   int checks = 0;
   int errors = 0;
   int exp_cnt = 0;

   logic [5:0] outs;
   assign outs = {pc_freeze, ifid_freeze, ifid_flush,
                  idex_flush, global_freeze, mem_ready};

   localparam logic [5:0] O_NONE  = 6'b000000;
   localparam logic [5:0] O_STALL = 6'b110100;
   localparam logic [5:0] O_BR    = 6'b001100;
   localparam logic [5:0] O_FRZ   = 6'b000010;
`ifdef FORWARDING_EN
   localparam logic [5:0] O_FWDX  = O_NONE;
`else
   localparam logic [5:0] O_FWDX  = O_STALL;
`endif

   pipe_hazard_ctrl #(.MEM_WAIT_CYCLES(4), .CNT_W(16)) dut (
      .clk(clk), .rst(rst),
      .id_src1(id_src1), .id_src2(id_src2),
      .id_two_src(id_two_src), .id_valid(id_valid),
      .exe_dest(exe_dest), .exe_wb_en(exe_wb_en),
      .exe_mem_r_en(exe_mem_r_en),
      .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
      .mem_req(mem_req), .branch_taken(branch_taken),
      .pc_freeze(pc_freeze), .ifid_freeze(ifid_freeze),
      .ifid_flush(ifid_flush), .idex_flush(idex_flush),
      .global_freeze(global_freeze), .mem_ready(mem_ready),
      .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1;
      id_src1 = 4'd0; id_src2 = 4'd0; exe_dest = 4'd0; mem_dest = 4'd0;
      id_two_src = 1'b0; id_valid = 1'b0; exe_wb_en = 1'b0;
      exe_mem_r_en = 1'b0; mem_wb_en = 1'b0; mem_req = 1'b0;
      branch_taken = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("reset_outs", 32'(outs), 32'(O_NONE));
      chk("reset_cnt", 32'(stall_cnt), 32'd0);

      // EXE match on src1
      @(negedge clk);
      id_valid = 1'b1; id_src1 = 4'd3; exe_dest = 4'd3; exe_wb_en = 1'b1;
      #1;
      chk("haz_src1", 32'(outs), 32'(O_FWDX));
      chk("haz_src1_cnt", 32'(stall_cnt), 32'd0);
      if (O_FWDX == O_STALL) exp_cnt++;

      @(negedge clk);
      branch_taken = 1'b1;
      #1;
      chk("br_over_haz", 32'(outs), 32'(O_BR));
      chk("cnt_after_haz", 32'(stall_cnt), 32'(exp_cnt));

      @(negedge clk);
      branch_taken = 1'b0; id_valid = 1'b0; exe_wb_en = 1'b0;
      #1;
      chk("br_one_cycle", 32'(outs), 32'(O_NONE));
      chk("cnt_after_br", 32'(stall_cnt), 32'(exp_cnt));

      // MEM match on src2
      @(negedge clk);
      id_valid = 1'b1; id_src1 = 4'd1; id_src2 = 4'd7; id_two_src = 1'b1;
      mem_dest = 4'd7; mem_wb_en = 1'b1;
      #1;
      chk("haz_src2_mem", 32'(outs), 32'(O_FWDX));
      if (O_FWDX == O_STALL) exp_cnt++;

      @(negedge clk);
      id_two_src = 1'b0; id_src2 = 4'd5; mem_dest = 4'd5;
      #1;
      chk("single_src", 32'(outs), 32'(O_NONE));
      chk("single_src_cnt", 32'(stall_cnt), 32'(exp_cnt));

      @(negedge clk);
      id_two_src = 1'b1; id_valid = 1'b0;
      #1;
      chk("id_invalid", 32'(outs), 32'(O_NONE));

      // load-use stalls in every build
      @(negedge clk);
      id_valid = 1'b1; id_two_src = 1'b0; mem_wb_en = 1'b0;
      id_src1 = 4'd9; exe_dest = 4'd9; exe_wb_en = 1'b1; exe_mem_r_en = 1'b1;
      #1;
      chk("load_use", 32'(outs), 32'(O_STALL));
      exp_cnt++;

      @(negedge clk);
      id_valid = 1'b0; exe_wb_en = 1'b0; exe_mem_r_en = 1'b0;
      #1;
      chk("load_use_clr", 32'(outs), 32'(O_NONE));
      chk("load_use_cnt", 32'(stall_cnt), 32'(exp_cnt));

      // memory access with branch and hazard pending
      @(negedge clk);
      mem_req = 1'b1; branch_taken = 1'b1;
      id_valid = 1'b1; id_src1 = 4'd2; exe_dest = 4'd2; exe_wb_en = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk($sformatf("mem_freeze%0d", k), 32'(outs), 32'(O_FRZ));
         @(negedge clk);
      end
      exp_cnt += 4;
      #1;
      chk("mem_done", 32'(outs), 32'(O_BR | 6'b000001));
      chk("mem_cnt", 32'(stall_cnt), 32'(exp_cnt));

      @(negedge clk);
      mem_req = 1'b0; branch_taken = 1'b0; id_valid = 1'b0; exe_wb_en = 1'b0;
      #1;
      chk("done_ignores_req", 32'(outs), 32'(O_NONE));
      chk("done_cnt", 32'(stall_cnt), 32'(exp_cnt));

      // reset during the second wait cycle
      @(negedge clk);
      mem_req = 1'b1;
      #1;
      chk("rw_idle", 32'(outs), 32'(O_FRZ));
      @(negedge clk);
      #1;
      chk("rw_wait1", 32'(outs), 32'(O_FRZ));
      @(negedge clk);
      rst = 1'b1; mem_req = 1'b0;
      #1;
      chk("rw_wait2", 32'(outs), 32'(O_FRZ));
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rw_after_rst", 32'(outs), 32'(O_NONE));
      chk("rw_cnt", 32'(stall_cnt), 32'd0);
      @(negedge clk);
      #1;
      chk("rw_no_ready", 32'(outs), 32'(O_NONE));

      // counter saturation under a held load-use stall
      @(negedge clk);
      id_valid = 1'b1; id_src1 = 4'd4; exe_dest = 4'd4;
      exe_wb_en = 1'b1; exe_mem_r_en = 1'b1;
      repeat (65540) @(negedge clk);
      #1;
      chk("sat_cnt", 32'(stall_cnt), 32'h0000ffff);
      chk("sat_outs", 32'(outs), 32'(O_STALL));
      @(negedge clk);
      #1;
      chk("sat_hold", 32'(stall_cnt), 32'h0000ffff);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central pipeline sequencer for the 5-stage ARM core. Detects RAW data hazards between the instruction in ID and the instructions in EXE/MEM. Sequences branch flushes and multi-cycle data-memory waits. Drives the freeze/flush controls of PC, IF/ID and ID/EX registers (the ID/EX register takes idex_flush on its flush input) plus the global freeze used by EXE/MEM and MEM/WB.

Parameters:
MEM_WAIT_CYCLES, 4, data-memory access latency in cycles (>=1)
CNT_W, 16, width of stall statistics counter

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
id_src1  in  4  Rn index of instruction in ID
id_src2  in  4  Rm/Rd index of instruction in ID
id_two_src  in  1  ID instruction reads id_src2
id_valid  in  1  ID holds a real instruction
exe_dest  in  4  dest register in EXE
exe_wb_en  in  1  EXE instruction writes back
exe_mem_r_en  in  1  EXE instruction is a load
mem_dest  in  4  dest register in MEM
mem_wb_en  in  1  MEM instruction writes back
mem_req  in  1  MEM stage has mem_r_en or mem_w_en set
branch_taken  in  1  EXE resolved a taken branch (B flag)
pc_freeze  out  1  hold PC
ifid_freeze  out  1  hold IF/ID
ifid_flush  out  1  clear IF/ID
idex_flush  out  1  clear ID/EX (bubble)
global_freeze  out  1  hold every pipeline register
mem_ready  out  1  one-cycle pulse: memory access complete
stall_cnt  out  CNT_W  saturating count of stall/freeze cycles

Behaviour:
- Clock is clk. Reset is rst, synchronous and active-high. At reset: state=IDLE, wait counter=0, stall_cnt=0, mem_ready=0.
- hazard (combinational):
  - Requires id_valid=1.
  - Set when any of the following holds: exe_wb_en && exe_dest==id_src1; mem_wb_en && mem_dest==id_src1; the same two checks on id_src2 when id_two_src=1.
- Memory FSM:
  - States: IDLE, WAIT, DONE.
  - IDLE: if mem_req=1, load counter = MEM_WAIT_CYCLES-1 and go to WAIT.
  - WAIT: decrement the counter. At 0, go to DONE.
  - DONE: mem_ready=1 for this cycle only, then go to IDLE.
  - A new mem_req seen in DONE is ignored. The MEM stage has advanced by IDLE, so a back-to-back access restarts from IDLE on the following cycle.
- global_freeze = (state==WAIT) or (state==IDLE && mem_req). Total freeze is exactly MEM_WAIT_CYCLES cycles per access.
- Priority, highest first:
  - global_freeze: all other outputs forced 0. Branch and hazard are re-evaluated after the freeze, because EXE/MEM contents are held.
  - branch_taken: ifid_flush=1, idex_flush=1, pc_freeze=0 for one cycle. A hazard in the same cycle is ignored, since the ID instruction is squashed.
  - hazard: pc_freeze=1, ifid_freeze=1, idex_flush=1.
- stall_cnt increments on any cycle with global_freeze or hazard stall, and saturates at all-ones.
- A reset during WAIT aborts the access immediately. global_freeze=0 from the next cycle.

Optional Feature:
- Macro: FORWARDING_EN.
- Defined: hazard is restricted to load-use, i.e. exe_mem_r_en && exe_wb_en && the exe_dest match on src1 (or on src2 when id_two_src=1). MEM-stage matches and non-load EXE matches do not stall, because the forwarding unit covers them.
- Undefined: full hazard rule as in Behaviour.

Test Plan:
- Hazard on src1: id_src1=3, exe_dest=3, exe_wb_en=1, id_valid=1 -> pc_freeze=ifid_freeze=idex_flush=1 the same cycle. stall_cnt goes 0->1.
- Branch over hazard: branch_taken=1 and the same hazard -> ifid_flush=idex_flush=1, pc_freeze=0, one cycle.
- Memory wait: MEM_WAIT_CYCLES=4, mem_req held -> global_freeze high for exactly 4 cycles, then mem_ready pulses 1 cycle. Other outputs stay 0 during the freeze. stall_cnt=4.
- Reset mid-WAIT: rst asserted at the 2nd wait cycle -> next cycle state IDLE, global_freeze=0, stall_cnt=0.
- Single-source check: id_two_src=0, id_src2=5, mem_dest=5, mem_wb_en=1 -> no stall.
- FORWARDING_EN defined: MEM-stage match -> no stall. EXE load (exe_mem_r_en=1) matching src1 -> one-cycle stall.
